// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
// State encoding, BCD digit limits, the packed time word and a digit-legality check.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    function automatic logic mmss_legal(input mmss_t t);
        return (t.min_tens <= BCD_MAX) && (t.min_ones <= BCD_MAX) &&
               (t.sec_tens <= SEC_TENS_MAX) && (t.sec_ones <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// 16-bit mm:ss BCD down-counter: clear > load > decrement, holds at 00:00.
// Latency 1 clk from control to count; no backpressure.
// Zero and one-second flags are decoded from the registered count.
module bcd_mmss_down
    import timer_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clr,
    input  logic  load,
    input  mmss_t load_val,
    input  logic  dec,
    output mmss_t count,
    output logic  zero,
    output logic  one
);

    mmss_t count_nxt;

    assign zero = (count == 16'h0000);
    assign one  = (count == 16'h0001);

    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = load_val;
        end else if (dec && !zero) begin
            // Ripple the borrow through the digits; the zero guard keeps the top digit from wrapping.
            if (count.sec_ones != 4'd0) begin
                count_nxt.sec_ones = count.sec_ones - 4'd1;
            end else begin
                count_nxt.sec_ones = BCD_MAX;
                if (count.sec_tens != 4'd0) begin
                    count_nxt.sec_tens = count.sec_tens - 4'd1;
                end else begin
                    count_nxt.sec_tens = SEC_TENS_MAX;
                    if (count.min_ones != 4'd0) begin
                        count_nxt.min_ones = count.min_ones - 4'd1;
                    end else begin
                        count_nxt.min_ones = BCD_MAX;
                        count_nxt.min_tens = count.min_tens - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown sequencer: start/pause/clear/load control of an mm:ss BCD count, timed alarm at 00:00.
// Latency 1 clk from any tick or control pulse to the registered outputs.
// No backpressure: every pulse is acted on or dropped in the cycle it arrives.
module countdown_timer_ctrl
    import timer_pkg::*;
#(
    parameter int ALARM_TICKS = 10,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        start_p,
    input  logic        pause_p,
    input  logic        clear_p,
    input  logic        load_en,
    input  logic [15:0] load_bcd,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        running,
    output logic        paused,
    output logic        alarm,
    output logic        done_p,
    output logic        load_err
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] alarm_cnt, alarm_cnt_nxt;
    logic             cnt_clr, cnt_load, cnt_dec, idle_load;
    logic             done_nxt, load_err_nxt;
    logic             cnt_zero, cnt_one;
    logic             start_ok, ack;
    mmss_t            count;
    mmss_t            load_val;

    assign load_val = mmss_t'(load_bcd);
    assign start_ok = start_p && !cnt_zero;
    assign ack      = start_p || pause_p || clear_p;

    bcd_mmss_down u_count (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (load_val),
        .dec      (cnt_dec),
        .count    (count),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    assign min_tens = count.min_tens;
    assign min_ones = count.min_ones;
    assign sec_tens = count.sec_tens;
    assign sec_ones = count.sec_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            alarm_cnt <= '0;
            running   <= 1'b0;
            paused    <= 1'b0;
            alarm     <= 1'b0;
            done_p    <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            running   <= (state_nxt == ST_RUN);
            paused    <= (state_nxt == ST_PAUSE);
            alarm     <= (state_nxt == ST_ALARM);
            done_p    <= done_nxt;
            load_err  <= load_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!clear_p && !pause_p && start_ok) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Reaching 00:00 outranks a same-cycle pause.
                if (clear_p)                  state_nxt = ST_IDLE;
                else if (tick_1hz && cnt_one) state_nxt = ST_ALARM;
                else if (pause_p)             state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (clear_p)                  state_nxt = ST_IDLE;
                else if (!pause_p && start_p) state_nxt = ST_RUN;
            end
            ST_ALARM: begin
                if (ack) state_nxt = ST_IDLE;
                else if (tick_1hz && (alarm_cnt <= CNT_W'(1))) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr       = (state != ST_ALARM) && clear_p;
        cnt_dec       = (state == ST_RUN) && !clear_p && tick_1hz;
        // A load only lands in an IDLE cycle where no clear or accepted start is acted on.
        idle_load     = (state == ST_IDLE) && load_en && !clear_p && !(!pause_p && start_ok);
        cnt_load      = idle_load && mmss_legal(load_val);
        load_err_nxt  = idle_load && !mmss_legal(load_val);
        done_nxt      = (state == ST_RUN) && (state_nxt == ST_ALARM);
        alarm_cnt_nxt = alarm_cnt;
        if (done_nxt) begin
            alarm_cnt_nxt = CNT_W'(ALARM_TICKS);
        end else if (state == ST_ALARM) begin
            if (ack)                                  alarm_cnt_nxt = '0;
            else if (tick_1hz && alarm_cnt != '0)     alarm_cnt_nxt = alarm_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl: inputs driven on the falling edge,
// outputs sampled on the following falling edge after the active rising edge.
module tb_countdown_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1hz = 1'b0, start_p = 1'b0, pause_p = 1'b0, clear_p = 1'b0, load_en = 1'b0;
    logic [15:0] load_bcd = '0;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic        running, paused, alarm, done_p, load_err;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer_ctrl #(.ALARM_TICKS(10), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .start_p  (start_p),
        .pause_p  (pause_p),
        .clear_p  (clear_p),
        .load_en  (load_en),
        .load_bcd (load_bcd),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .paused   (paused),
        .alarm    (alarm),
        .done_p   (done_p),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given pulses held across the rising edge.
    task automatic step(input logic t = 0, input logic s = 0, input logic p = 0, input logic c = 0,
                        input logic l = 0, input logic [15:0] v = 16'h0, input logic r = 0);
        tick_1hz = t; start_p = s; pause_p = p; clear_p = c; load_en = l; load_bcd = v; rst = r;
        @(negedge clk);
        tick_1hz = 0; start_p = 0; pause_p = 0; clear_p = 0; load_en = 0; load_bcd = '0; rst = 0;
    endtask

    initial begin
        @(negedge clk);
        step(0, 0, 0, 0, 0, 16'h0, 1);
        step(0, 0, 0, 0, 0, 16'h0, 1);
        check("rst_digits", 32'(digits()), 32'h0000);
        check("rst_flags", {27'd0, running, paused, alarm, done_p, load_err}, 32'd0);

        // Full countdown from 01:02 and the alarm window.
        step(0, 0, 0, 0, 1, 16'h0102);
        check("load_0102", 32'(digits()), 32'h0102);
        step(0, 1);
        check("start_run", 32'(running), 32'd1);
        for (int i = 1; i <= 62; i++) begin
            step(1);
            check($sformatf("count_t%0d", i), 32'(digits()), 32'(secs_to_bcd(62 - i)));
            check($sformatf("done_t%0d", i), 32'(done_p), (i == 62) ? 32'd1 : 32'd0);
        end
        check("alarm_on", 32'(alarm), 32'd1);
        check("run_off_alarm", 32'(running), 32'd0);
        step();
        check("done_single", 32'(done_p), 32'd0);
        for (int j = 1; j <= 10; j++) begin
            step(1);
            check($sformatf("alarm_t%0d", j), 32'(alarm), (j < 10) ? 32'd1 : 32'd0);
        end
        check("idle_after_alarm", {30'd0, running, paused}, 32'd0);

        // Borrow chain and maximum count.
        step(0, 0, 0, 0, 1, 16'h1000);
        step(0, 1);
        step(1);
        check("borrow_0959", 32'(digits()), 32'h0959);
        step(0, 0, 0, 1);
        check("clear_run", 32'(digits()), 32'h0000);
        step(0, 0, 0, 0, 1, 16'h9959);
        check("load_max", 32'(digits()), 32'h9959);

        // Illegal loads and loads outside IDLE.
        step(0, 0, 0, 0, 1, 16'h0060);
        check("err_0060", 32'(load_err), 32'd1);
        check("hold_0060", 32'(digits()), 32'h9959);
        step();
        check("err_drops", 32'(load_err), 32'd0);
        step(0, 0, 0, 0, 1, 16'h0A00);
        check("err_0A00", 32'(load_err), 32'd1);
        check("hold_0A00", 32'(digits()), 32'h9959);
        step(0, 1);
        step(0, 0, 0, 0, 1, 16'h0102);
        check("load_in_run", 32'(digits()), 32'h9959);
        check("no_err_run", 32'(load_err), 32'd0);
        step(0, 0, 0, 1);

        // Pause / resume / clear at 00:30.
        step(0, 0, 0, 0, 1, 16'h0030);
        step(0, 1);
        step(1, 0, 1);
        check("pause_tick", 32'(digits()), 32'h0029);
        check("paused", {30'd0, running, paused}, 32'd1);
        for (int k = 0; k < 5; k++) step(1);
        check("pause_hold", 32'(digits()), 32'h0029);
        step(0, 1);
        check("resume", {30'd0, running, paused}, 32'd2);
        check("resume_no_dec", 32'(digits()), 32'h0029);
        step(1, 1, 0, 1);
        check("clear_prio", 32'(digits()), 32'h0000);
        check("clear_idle", {30'd0, running, paused}, 32'd0);

        // Reaching 00:00 outranks a coincident pause.
        step(0, 0, 0, 0, 1, 16'h0001);
        step(0, 1);
        step(1, 0, 1);
        check("alarm_vs_pause", {29'd0, running, paused, alarm}, 32'd1);
        step(0, 0, 0, 1);
        check("clear_ack", 32'(alarm), 32'd0);

        // Acknowledge with start after 3 alarm ticks.
        step(0, 0, 0, 0, 1, 16'h0001);
        step(0, 1);
        step(1);
        check("alarm_enter", {30'd0, alarm, done_p}, 32'd3);
        for (int k = 0; k < 3; k++) step(1);
        check("alarm_hold", 32'(alarm), 32'd1);
        step(0, 1);
        check("start_ack", {29'd0, running, paused, alarm}, 32'd0);

        // Reset mid-RUN at 05:17.
        step(0, 0, 0, 0, 1, 16'h0517);
        step(0, 1);
        check("run_0517", 32'(digits()), 32'h0517);
        step(1, 0, 0, 0, 0, 16'h0, 1);
        check("rst_run_digits", 32'(digits()), 32'h0000);
        check("rst_run_flags", {29'd0, running, alarm, done_p}, 32'd0);

        // Start ignored at 00:00; tick coincident with start from IDLE.
        step(0, 1);
        check("start_zero", 32'(running), 32'd0);
        step(0, 0, 0, 0, 1, 16'h0005);
        step(1, 1);
        check("start_tick_run", 32'(running), 32'd1);
        check("start_tick_hold", 32'(digits()), 32'h0005);
        step(1);
        check("first_dec", 32'(digits()), 32'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
